// File: rtl/pmem_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of the instruction, data and shared physical-memory line ports.
// A requester raises READ or WRITE and holds address/data until its RESP pulse.
// RESP is a single-cycle completion strobe; there is no separate ready signal.
interface pmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic              i_write;
  logic [LINE_W-1:0] i_wdata;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic [ADDR_W-1:0] p_addr;
  logic              p_read;
  logic              p_write;
  logic [LINE_W-1:0] p_wdata;
  logic [LINE_W-1:0] p_rdata;
  logic              p_resp;

  modport slave (
    input  i_addr, i_read, i_write, i_wdata,
    output i_rdata, i_resp,
    input  d_addr, d_read, d_write, d_wdata,
    output d_rdata, d_resp,
    output p_addr, p_read, p_write, p_wdata,
    input  p_rdata, p_resp
  );

  modport master (
    output i_addr, i_read, i_write, i_wdata,
    input  i_rdata, i_resp,
    output d_addr, d_read, d_write, d_wdata,
    input  d_rdata, d_resp,
    input  p_addr, p_read, p_write, p_wdata,
    output p_rdata, p_resp
  );
endinterface

// File: rtl/pmem_arbiter.sv
`timescale 1ns/1ps
// Round-robin, non-preemptive arbiter sharing one physical memory port between
// the instruction and data line adaptors, with sticky timeout/illegal-strobe flags.
module pmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic            clk,
  input  logic            rst_n,
  pmem_arbiter_if.slave   io_bus,
  output logic            o_gnt_d,
  output logic            o_err_timeout,
  output logic            o_err_rw,
  output logic [1:0]      o_state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             r_last;        // 1 = data was granted last
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_err_to;
  logic             r_err_rw;

  logic w_i_pend, w_d_pend, w_in_grant, w_rw_bad;

  logic [ADDR_W-1:0] w_p_addr;
  logic              w_p_read;
  logic              w_p_write;
  logic [LINE_W-1:0] w_p_wdata;
  logic              w_i_resp;
  logic              w_d_resp;

  assign w_i_pend   = io_bus.i_read | io_bus.i_write;
  assign w_d_pend   = io_bus.d_read | io_bus.d_write;
  assign w_in_grant = (r_state == GRANT_I) || (r_state == GRANT_D);
  assign w_rw_bad   = (io_bus.i_read & io_bus.i_write) | (io_bus.d_read & io_bus.d_write);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_i_pend && w_d_pend) w_next = r_last ? GRANT_I : GRANT_D;
        else if (w_d_pend)        w_next = GRANT_D;
        else if (w_i_pend)        w_next = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (io_bus.p_resp) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter sits at zero while idle so every grant starts counting from zero.
  always_comb begin
    w_cnt_next = r_cnt;
    if (!w_in_grant)            w_cnt_next = '0;
    else if (r_cnt != CNT_MAX)  w_cnt_next = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b0;
      r_cnt    <= '0;
      r_err_to <= 1'b0;
      r_err_rw <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_in_grant && io_bus.p_resp) r_last <= (r_state == GRANT_D);
      if (w_in_grant && (w_cnt_next == CNT_MAX)) r_err_to <= 1'b1;
      if (w_rw_bad) r_err_rw <= 1'b1;
    end
  end

  // A READ+WRITE collision forwards only the read.
  always_comb begin
    w_p_addr  = '0;
    w_p_read  = 1'b0;
    w_p_write = 1'b0;
    w_p_wdata = '0;
    w_i_resp  = 1'b0;
    w_d_resp  = 1'b0;
    case (r_state)
      GRANT_I: begin
        w_p_addr  = io_bus.i_addr;
        w_p_read  = io_bus.i_read;
        w_p_write = io_bus.i_write & ~io_bus.i_read;
        w_p_wdata = io_bus.i_wdata;
        w_i_resp  = io_bus.p_resp;
      end
      GRANT_D: begin
        w_p_addr  = io_bus.d_addr;
        w_p_read  = io_bus.d_read;
        w_p_write = io_bus.d_write & ~io_bus.d_read;
        w_p_wdata = io_bus.d_wdata;
        w_d_resp  = io_bus.p_resp;
      end
      default: ;
    endcase
  end

  assign io_bus.p_addr  = w_p_addr;
  assign io_bus.p_read  = w_p_read;
  assign io_bus.p_write = w_p_write;
  assign io_bus.p_wdata = w_p_wdata;
  assign io_bus.i_resp  = w_i_resp;
  assign io_bus.d_resp  = w_d_resp;
  assign io_bus.i_rdata = io_bus.p_rdata;
  assign io_bus.d_rdata = io_bus.p_rdata;

  assign o_gnt_d       = (r_state == GRANT_D);
  assign o_err_timeout = r_err_to;
  assign o_err_rw      = r_err_rw;
  assign o_state       = r_state;

endmodule

// File: tb/tb_pmem_arbiter.sv
`timescale 1ns/1ps
// Bench for pmem_arbiter: cycle vector table, hand-written corner sequences,
// then a randomized two-requester run against a memory responder.
module tb_pmem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [1:0] S0 = 2'd0, SI = 2'd1, SD = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gnt_d, err_to, err_rw;
  logic [1:0] state;

  pmem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

  pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n), .io_bus(bus),
    .o_gnt_d(gnt_d), .o_err_timeout(err_to), .o_err_rw(err_rw), .o_state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [LW-1:0] exp_i_q[$];
  logic [LW-1:0] exp_d_q[$];
  logic i_done, d_done;

  typedef struct {
    logic ir, iw; logic [31:0] ia;
    logic dr, dw; logic [31:0] da;
    logic pr;     logic [31:0] pd;
    logic e_pr, e_pw; logic [31:0] e_addr;
    logic e_ir, e_dr, e_gnt; logic [1:0] e_st; logic e_rw;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic ir, iw, input logic [31:0] ia,
                              input logic dr, dw, input logic [31:0] da,
                              input logic pr, input logic [31:0] pd,
                              input logic e_pr, e_pw, input logic [31:0] e_addr,
                              input logic e_ir, e_dr, e_gnt, input logic [1:0] e_st,
                              input logic e_rw);
    vec_t v;
    v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.pr = pr; v.pd = pd; v.e_pr = e_pr; v.e_pw = e_pw; v.e_addr = e_addr;
    v.e_ir = e_ir; v.e_dr = e_dr; v.e_gnt = e_gnt; v.e_st = e_st; v.e_rw = e_rw;
    return v;
  endfunction

  function automatic logic [LW-1:0] wmodel(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction

  function automatic logic [LW-1:0] rmodel(input logic [31:0] a);
    return {4{a + 32'h0000_1234, ~a}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.i_addr = '0; bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_wdata = '0;
    bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
    bus.p_rdata = '0; bus.p_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state",
          LW'({bus.p_read, bus.p_write, bus.i_resp, bus.d_resp, gnt_d, err_to, err_rw, state, bus.p_addr}),
          '0);
    rst_n = 1'b1;
  endtask

  task automatic run_vectors();
    logic [63:0] act, exp;
    logic [LW-1:0] pd_line, wd_exp;
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge clk); #1;
      bus.i_read = vecs[k].ir; bus.i_write = vecs[k].iw; bus.i_addr = vecs[k].ia;
      bus.i_wdata = wmodel(vecs[k].ia);
      bus.d_read = vecs[k].dr; bus.d_write = vecs[k].dw; bus.d_addr = vecs[k].da;
      bus.d_wdata = wmodel(vecs[k].da);
      bus.p_resp = vecs[k].pr; bus.p_rdata = {8{vecs[k].pd}};
      @(negedge clk);
      pd_line = {8{vecs[k].pd}};
      wd_exp  = (vecs[k].e_st == S0) ? '0 : wmodel(vecs[k].e_addr);
      act = {20'd0, bus.p_read, bus.p_write, bus.i_resp, bus.d_resp, gnt_d, err_to, err_rw,
             state, bus.p_addr, bus.i_rdata == pd_line, bus.d_rdata == pd_line,
             bus.p_wdata == wd_exp};
      exp = {20'd0, vecs[k].e_pr, vecs[k].e_pw, vecs[k].e_ir, vecs[k].e_dr, vecs[k].e_gnt,
             1'b0, vecs[k].e_rw, vecs[k].e_st, vecs[k].e_addr, 3'b111};
      check($sformatf("vec%0d", k), LW'(act), LW'(exp));
    end
  endtask

  task automatic drive_port(input int port, input int n);
    logic [31:0] a;
    logic rd, got;
    int cyc;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      a  = $urandom & 32'hFFFF_FFE0;
      rd = 1'($urandom_range(0, 1));
      if (port == 0) begin
        bus.i_addr = a; bus.i_read = rd; bus.i_write = ~rd; bus.i_wdata = wmodel(a);
        exp_i_q.push_back(rmodel(a));
      end else begin
        bus.d_addr = a; bus.d_read = rd; bus.d_write = ~rd; bus.d_wdata = wmodel(a);
        exp_d_q.push_back(rmodel(a));
      end
      cyc = 0; got = 1'b0;
      while (!got && cyc < 300) begin
        @(negedge clk);
        cyc++;
        got = (port == 0) ? bus.i_resp : bus.d_resp;
      end
      if (!got) check($sformatf("resp_wait_p%0d", port), '0, LW'(1));
      @(posedge clk); #1;
      if (port == 0) begin bus.i_read = 1'b0; bus.i_write = 1'b0; end
      else           begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    end
    if (port == 0) i_done = 1'b1; else d_done = 1'b1;
  endtask

  task automatic responder();
    while (!(i_done && d_done)) begin
      @(negedge clk);
      if (bus.p_read || bus.p_write) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        bus.p_resp  = 1'b1;
        bus.p_rdata = rmodel(bus.p_addr);
        if (bus.p_write) check("p_wdata", bus.p_wdata, wmodel(bus.p_addr));
        @(posedge clk); #1;
        bus.p_resp  = 1'b0;
        bus.p_rdata = {8{$urandom}};
      end
    end
  endtask

  task automatic monitor();
    while (!(i_done && d_done)) begin
      @(negedge clk);
      if (bus.i_resp && bus.d_resp) check("dual_resp", LW'(1), '0);
      if (bus.i_resp) begin
        if (exp_i_q.size() == 0) check("i_unexpected", LW'(1), '0);
        else check("i_rdata", bus.i_rdata, exp_i_q.pop_front());
      end
      if (bus.d_resp) begin
        if (exp_d_q.size() == 0) check("d_unexpected", LW'(1), '0);
        else check("d_rdata", bus.d_rdata, exp_d_q.pop_front());
      end
    end
  endtask

  initial begin
    // seq: single instruction read
    vecs.push_back(mk(1,0,32'h1000, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1,0,32'h1000, 0,0,0, 0,0, 1,0,32'h1000, 0,0,0,SI,0));
    vecs.push_back(mk(1,0,32'h1000, 0,0,0, 1,32'hAAAA_0001, 1,0,32'h1000, 1,0,0,SI,0));
    vecs.push_back(mk(0,0,32'h1000, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,0));
    // seq: tie resolved to data, then alternation
    vecs.push_back(mk(1,0,32'h2000, 0,1,32'h3000, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(1,0,32'h2000, 0,1,32'h3000, 0,0, 0,1,32'h3000, 0,0,1,SD,0));
    vecs.push_back(mk(1,0,32'h2000, 0,1,32'h3000, 1,32'hBBBB_0002, 0,1,32'h3000, 0,1,1,SD,0));
    vecs.push_back(mk(1,0,32'h2000, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(1,0,32'h2000, 0,0,0, 0,0, 1,0,32'h2000, 0,0,0,SI,0));
    vecs.push_back(mk(1,0,32'h2000, 0,0,0, 1,32'hCCCC_0003, 1,0,32'h2000, 1,0,0,SI,0));
    vecs.push_back(mk(1,0,32'h2100, 1,0,32'h3100, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(1,0,32'h2100, 1,0,32'h3100, 0,0, 1,0,32'h3100, 0,0,1,SD,0));
    vecs.push_back(mk(1,0,32'h2100, 1,0,32'h3100, 1,32'hDDDD_0004, 1,0,32'h3100, 0,1,1,SD,0));
    vecs.push_back(mk(1,0,32'h2100, 1,0,32'h3200, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(1,0,32'h2100, 1,0,32'h3200, 0,0, 1,0,32'h2100, 0,0,0,SI,0));
    vecs.push_back(mk(1,0,32'h2100, 1,0,32'h3200, 1,32'hEEEE_0005, 1,0,32'h2100, 1,0,0,SI,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h3200, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h3200, 0,0, 1,0,32'h3200, 0,0,1,SD,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h3200, 1,32'hFFFF_0006, 1,0,32'h3200, 0,1,1,SD,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,0));
    // seq: data request during instruction grant does not preempt
    vecs.push_back(mk(1,0,32'h4000, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(1,0,32'h4000, 0,0,0, 0,0, 1,0,32'h4000, 0,0,0,SI,0));
    vecs.push_back(mk(1,0,32'h4000, 1,0,32'h5000, 0,0, 1,0,32'h4000, 0,0,0,SI,0));
    vecs.push_back(mk(1,0,32'h4000, 1,0,32'h5000, 0,0, 1,0,32'h4000, 0,0,0,SI,0));
    vecs.push_back(mk(1,0,32'h4000, 1,0,32'h5000, 1,32'h1234_0007, 1,0,32'h4000, 1,0,0,SI,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h5000, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h5000, 0,0, 1,0,32'h5000, 0,0,1,SD,0));
    vecs.push_back(mk(0,0,0, 1,0,32'h5000, 1,32'h5678_0008, 1,0,32'h5000, 0,1,1,SD,0));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,0));
    // seq: stray P_RESP, READ+WRITE collision, early deassert
    vecs.push_back(mk(0,0,0, 0,0,0, 1,32'h9999_0009, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(1,1,32'h6000, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,0));
    vecs.push_back(mk(1,1,32'h6000, 0,0,0, 0,0, 1,0,32'h6000, 0,0,0,SI,1));
    vecs.push_back(mk(0,0,32'h6000, 0,0,0, 0,0, 0,0,32'h6000, 0,0,0,SI,1));
    vecs.push_back(mk(0,0,32'h6000, 0,0,0, 1,32'h7777_000A, 0,0,32'h6000, 1,0,0,SI,1));
    vecs.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,S0,1));

    clear_inputs();
    do_reset();
    run_vectors();

    // timeout: grant held 10 cycles with no response
    do_reset();
    @(posedge clk); #1;
    bus.i_addr = 32'h7000; bus.i_read = 1'b1;
    for (int g = 1; g <= 10; g++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (g == 5)  check("timeout_early", LW'(err_to), '0);
      if (g == 10) check("timeout_set", LW'({err_to, state, bus.p_read}), LW'({1'b1, SI, 1'b1}));
    end
    @(posedge clk); #1;
    bus.p_resp = 1'b1;
    @(negedge clk);
    check("timeout_resp", LW'(bus.i_resp), LW'(1));
    @(posedge clk); #1;
    bus.p_resp = 1'b0; bus.i_read = 1'b0;
    @(negedge clk);
    check("timeout_sticky", LW'({err_to, state}), LW'({1'b1, S0}));

    // reset asserted in the middle of a data grant
    @(posedge clk); #1;
    bus.d_addr = 32'h8000; bus.d_write = 1'b1; bus.d_wdata = wmodel(32'h8000);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_grant", LW'({gnt_d, bus.p_write, state}), LW'({1'b1, 1'b1, SD}));
    #2;
    rst_n = 1'b0;
    bus.p_resp = 1'b1;
    #1;
    check("reset_async",
          LW'({gnt_d, bus.p_write, bus.p_read, bus.d_resp, state, err_to}), '0);
    bus.d_write = 1'b0; bus.p_resp = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release", LW'({state, bus.d_resp, bus.i_resp, gnt_d}), '0);

    // randomized two-requester traffic
    do_reset();
    i_done = 1'b0; d_done = 1'b0;
    fork
      drive_port(0, 20);
      drive_port(1, 20);
      responder();
      monitor();
    join
    check("i_q_drained", LW'(exp_i_q.size()), '0);
    check("d_q_drained", LW'(exp_d_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 32, physical address width.
REQ-002 The block SHALL have parameter LINE_W, default 256, cache-line data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1023, maximum grant cycles before the timeout flag sets.

Interface
REQ-004 CLK  in  1  single clock, rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 I_ADDR/I_READ/I_WRITE/I_WDATA  in  ADDR_W/1/1/LINE_W  instruction line-adaptor request; held stable until I_RESP.
REQ-007 I_RDATA/I_RESP  out  LINE_W/1  instruction read data and completion pulse.
REQ-008 D_ADDR/D_READ/D_WRITE/D_WDATA  in  ADDR_W/1/1/LINE_W  data line-adaptor request; held stable until D_RESP.
REQ-009 D_RDATA/D_RESP  out  LINE_W/1  data read data and completion pulse.
REQ-010 P_ADDR/P_READ/P_WRITE/P_WDATA  out  ADDR_W/1/1/LINE_W  request to the shared physical memory.
REQ-011 P_RDATA/P_RESP  in  LINE_W/1  physical memory read data and completion.
REQ-012 GNT_D  out  1  1 while the data port owns memory.
REQ-013 ERR_TIMEOUT  out  1  sticky, a grant exceeded TIMEOUT_CYC.
REQ-014 ERR_RW  out  1  sticky, a requester asserted READ and WRITE together.

Function
REQ-015 FSM states SHALL be IDLE, GRANT_I, GRANT_D; state registered on CLK.
REQ-016 A request SHALL be "pending" when READ or WRITE is asserted on that port.
REQ-017 In IDLE with one port pending, the FSM SHALL move to that port's GRANT state on the next edge.
REQ-018 In IDLE with both ports pending, the FSM SHALL grant the port not granted last (round-robin via a 1-bit LAST register); after reset LAST indicates instruction, so data wins the first tie.
REQ-019 In GRANT_x, P_ADDR/P_READ/P_WRITE/P_WDATA SHALL combinationally follow port x; in IDLE, P_READ and P_WRITE SHALL be 0 and P_ADDR/P_WDATA SHALL be 0.
REQ-020 x_RDATA SHALL equal P_RDATA for both ports at all times; x_RESP SHALL equal P_RESP only in GRANT_x, else 0.
REQ-021 On P_RESP in GRANT_x, the FSM SHALL return to IDLE on the next edge and set LAST to x.
REQ-022 Grants SHALL be non-preemptive: a new request on the other port never changes state while granted.
REQ-023 Latency: request first pending at cycle N (in IDLE) -> P strobe at N+1; P_RESP at cycle M -> x_RESP at M, IDLE at M+1, earliest next grant strobe at M+2.
REQ-024 P_RESP while in IDLE SHALL be ignored (no RESP to either port, no state change).
REQ-025 If the granted port deasserts READ/WRITE before P_RESP, the FSM SHALL remain in GRANT_x until P_RESP.
REQ-026 A grant-cycle counter SHALL clear on entering a GRANT state, increment each GRANT cycle, and saturate at TIMEOUT_CYC.
REQ-027 ERR_TIMEOUT SHALL set when the counter reaches TIMEOUT_CYC; the grant SHALL NOT be aborted.
REQ-028 ERR_RW SHALL set on any cycle where either port has READ=WRITE=1; in that case the arbiter SHALL forward only the READ to P (P_WRITE=0).
REQ-029 GNT_D SHALL be 1 exactly in GRANT_D.

Reset
REQ-030 RST_N low SHALL immediately force state IDLE, LAST=instruction, counter 0, ERR_TIMEOUT=0, ERR_RW=0, all RESP/strobe outputs 0 and GNT_D=0, independent of CLK.
REQ-031 Reset assertion mid-grant SHALL drop P strobes at once; no RESP SHALL be delivered for the aborted transaction.

Verification
REQ-032 Single inst read: I_READ=1, I_ADDR=0x0000_1000 at cycle 0, P_RESP at cycle 5 with P_RDATA=pattern A -> P_READ=1 with P_ADDR=0x1000 on cycles 1-5, I_RESP=1 and I_RDATA=A at cycle 5, D_RESP=0 throughout, IDLE at cycle 6.
REQ-033 Simultaneous requests: I_READ and D_WRITE both rise at cycle 0 after reset -> data granted first (P_WRITE=1, GNT_D=1), instruction granted at 2 cycles after D_RESP; repeat with both pending -> grant alternates I, D, I.
REQ-034 Non-preemption: D_READ rises while GRANT_I -> P_ADDR stays I_ADDR until P_RESP; D granted afterwards.
REQ-035 Timeout: TIMEOUT_CYC=8, grant with no P_RESP for 10 cycles -> ERR_TIMEOUT=1 from 8th grant cycle, stays 1 after later P_RESP, until RST_N.
REQ-036 Reset mid-grant: RST_N low during GRANT_D -> P_WRITE/P_READ/GNT_D low same cycle, no D_RESP, state IDLE after release.
REQ-037 Illegal strobes: I_READ=I_WRITE=1 -> ERR_RW=1, P_READ=1, P_WRITE=0; stray P_RESP in IDLE -> no RESP outputs.
